seq_pattern_gen: RTL and testbench

- Serial pattern transmitter: the source side of the serial sequence-detector interface.
- Emits a fixed N-bit pattern (default 11011), MSB first, one bit per clk, for a programmed number of frames, with optional idle gap between frames.
- Used to drive detector FSMs in-system and as a stimulus source.
- Moore-style: all outputs are registered and depend only on state and registers.

---
 rtl/seq_pattern_gen.sv | 174 +++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a fixed N-bit pattern MSB first for a programmed number of frames.
// Optional PATGEN_RUNTIME_PAT_EN adds pat_in/pat_len ports so the pattern is latched at start.
module seq_pattern_gen #(
  parameter int unsigned      PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b11011,
  parameter int unsigned      GAP     = 2,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] frames,
`ifdef PATGEN_RUNTIME_PAT_EN
  input  logic [PAT_W-1:0] pat_in,
  input  logic [4:0]       pat_len,
`endif
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned IDX_W = $clog2(PAT_W);
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               stop_q, stop_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               out_q, out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W:0]     cnt_inc;
  logic               start_acc;
  logic [PAT_W-1:0]   pat_cur;
  logic [IDX_W-1:0]   last_cur;

  assign start_acc = (state_q == ST_IDLE) && start;

`ifdef PATGEN_RUNTIME_PAT_EN
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             len_ok;

  // Runtime pattern and length are captured on start; out-of-range lengths fall back to PAT_W.
  always_comb begin
    len_ok = (pat_len >= 5'd2) && (pat_len <= 5'(PAT_W));
    pat_d  = pat_q;
    last_d = last_q;
    if (start_acc) begin
      pat_d  = pat_in;
      last_d = len_ok ? IDX_W'(pat_len - 5'd1) : IDX_W'(PAT_W - 1);
    end
    pat_cur  = pat_d;
    last_cur = last_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PATTERN;
      last_q <= IDX_W'(PAT_W - 1);
    end else begin
      pat_q  <= pat_d;
      last_q <= last_d;
    end
  end
`else
  assign pat_cur  = PATTERN;
  assign last_cur = IDX_W'(PAT_W - 1);
`endif

  // Next-state and registered-output logic; outputs reflect the state being entered.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    target_d    = target_q;
    frame_cnt_d = frame_cnt_q;
    stop_d      = stop_q;
    gap_cnt_d   = gap_cnt_q;
    cnt_inc     = {1'b0, frame_cnt_q} + (CNT_W + 1)'(1);

    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          target_d    = frames;
          frame_cnt_d = '0;
          stop_d      = 1'b0;
          idx_d       = last_cur;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        stop_d = stop_q | stop;
        if (idx_q == '0) begin
          frame_cnt_d = (frame_cnt_q == CNT_MAX) ? frame_cnt_q : cnt_inc[CNT_W-1:0];
          idx_d       = last_cur;
          if (((target_q != '0) && (cnt_inc == {1'b0, target_q})) || stop_q || stop) begin
            state_d = ST_DONE;
          end else if (GAP > 0) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_GAP: begin
        stop_d = stop_q | stop;
        if (gap_cnt_q == GAP_W'(GAP - 1)) begin
          state_d = (stop_q || stop) ? ST_DONE : ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = (state_d == ST_SEND);
    out_d   = valid_d & pat_cur[idx_d];
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= IDX_W'(PAT_W - 1);
      target_q    <= '0;
      frame_cnt_q <= '0;
      stop_q      <= 1'b0;
      gap_cnt_q   <= '0;
      out_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      target_q    <= target_d;
      frame_cnt_q <= frame_cnt_d;
      stop_q      <= stop_d;
      gap_cnt_q   <= gap_cnt_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Randomized bench for seq_pattern_gen: two instances (GAP=2 and GAP=0) share stimulus and are
// compared slot by slot against a frame-schedule model built from the transmission rules.
module tb_seq_pattern_gen;

  localparam int unsigned PAT_W = 5;
  localparam int unsigned CNT_W = 8;
  localparam int          MAXS  = 2100;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam logic [PAT_W-1:0] PATTERN = 5'b11011;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] frames;
  logic             out_w   [2];
  logic             valid_w [2];
  logic             busy_w  [2];
  logic             done_w  [2];
  logic [CNT_W-1:0] cnt_w   [2];
`ifdef PATGEN_RUNTIME_PAT_EN
  logic [PAT_W-1:0] pat_in;
  logic [4:0]       pat_len;
`endif

  seq_pattern_gen #(.PAT_W(PAT_W), .PATTERN(PATTERN), .GAP(2), .CNT_W(CNT_W)) u_dut_gap2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .frames(frames),
`ifdef PATGEN_RUNTIME_PAT_EN
    .pat_in(pat_in), .pat_len(pat_len),
`endif
    .out(out_w[0]), .valid(valid_w[0]), .busy(busy_w[0]), .done(done_w[0]), .frame_cnt(cnt_w[0])
  );

  seq_pattern_gen #(.PAT_W(PAT_W), .PATTERN(PATTERN), .GAP(0), .CNT_W(CNT_W)) u_dut_gap0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .frames(frames),
`ifdef PATGEN_RUNTIME_PAT_EN
    .pat_in(pat_in), .pat_len(pat_len),
`endif
    .out(out_w[1]), .valid(valid_w[1]), .busy(busy_w[1]), .done(done_w[1]), .frame_cnt(cnt_w[1])
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit e_out   [2][MAXS];
  bit e_valid [2][MAXS];
  bit e_busy  [2][MAXS];
  bit e_done  [2][MAXS];
  int e_cnt   [2][MAXS];
  int e_len   [2];
  int last_cnt[2];
  int gap_of  [2] = '{2, 0};

  logic [PAT_W-1:0] cur_pat = PATTERN;
  int               cur_len = PAT_W;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_slot(input int d, input int t, input bit v, input bit o, input bit b,
                          input bit dn, input int c);
    e_valid[d][t] = v;
    e_out[d][t]   = o;
    e_busy[d][t]  = b;
    e_done[d][t]  = dn;
    e_cnt[d][t]   = c;
  endtask

  // Slot t = t-th cycle after start is sampled; stop seen in slot s ends the run at the next boundary.
  task automatic build(input int d, input int gap, input int f, input int s);
    int t = 1;
    int cnt = 0;
    int nf = 0;
    bit stopped = 0;
    bit fin = 0;
    while (!fin && t < MAXS - gap - PAT_W - 4) begin
      for (int b = cur_len - 1; b >= 0; b--) begin
        set_slot(d, t, 1, cur_pat[b], 1, 0, cnt);
        if (t == s) stopped = 1;
        t++;
      end
      nf++;
      if (cnt < CMAX) cnt++;
      if ((f != 0 && nf == f) || stopped) begin
        set_slot(d, t, 0, 0, 1, 1, cnt);
        t++;
        fin = 1;
      end else begin
        for (int g = 0; g < gap; g++) begin
          set_slot(d, t, 0, 0, 1, 0, cnt);
          if (t == s) stopped = 1;
          t++;
        end
        if (stopped) begin
          set_slot(d, t, 0, 0, 1, 1, cnt);
          t++;
          fin = 1;
        end
      end
    end
    e_len[d] = t;
    for (int k = t; k < MAXS; k++) set_slot(d, k, 0, 0, 0, 0, cnt);
  endtask

  task automatic check_outputs(input int d, input string where, input bit v, input bit o,
                               input bit b, input bit dn, input int c);
    check($sformatf("%s.d%0d.valid", where, d), 32'(valid_w[d]), 32'(v));
    check($sformatf("%s.d%0d.out", where, d), 32'(out_w[d]), 32'(o));
    check($sformatf("%s.d%0d.busy", where, d), 32'(busy_w[d]), 32'(b));
    check($sformatf("%s.d%0d.done", where, d), 32'(done_w[d]), 32'(dn));
    check($sformatf("%s.d%0d.cnt", where, d), 32'(cnt_w[d]), 32'(c));
  endtask

`ifdef PATGEN_RUNTIME_PAT_EN
  task automatic set_pattern(input logic [PAT_W-1:0] p, input logic [4:0] l);
    pat_in  = p;
    pat_len = l;
    cur_pat = p;
    cur_len = (l >= 2 && l <= PAT_W) ? int'(l) : PAT_W;
  endtask
`endif

  task automatic run_case(input int f, input int s, input int r);
    int total;
    bit aborted = 0;
    for (int d = 0; d < 2; d++) build(d, gap_of[d], f, s);
    total = ((e_len[0] > e_len[1]) ? e_len[0] : e_len[1]) + 1;
    @(negedge clk);
    frames = CNT_W'(f);
    start  = 1'b1;
    stop   = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int t = 1; t <= total && !aborted; t++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      if (r != 0 && t == r + 1) begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
          check_outputs(d, $sformatf("abort.t%0d", t), 0, 0, 0, 0, 0);
          last_cnt[d] = 0;
        end
        aborted = 1;
      end else begin
        for (int d = 0; d < 2; d++)
          check_outputs(d, $sformatf("f%0d.s%0d.t%0d", f, s, t), e_valid[d][t], e_out[d][t],
                        e_busy[d][t], e_done[d][t], e_cnt[d][t]);
        stop   = (t == s);
        start  = (t <= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        frames = CNT_W'($urandom);
        if (t == r) rst = 1'b1;
        @(posedge clk);
      end
    end
    if (!aborted) for (int d = 0; d < 2; d++) last_cnt[d] = e_cnt[d][MAXS-1];
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'($urandom_range(0, 1));
      for (int d = 0; d < 2; d++) check_outputs(d, $sformatf("idle%0d", i), 0, 0, 0, 0, last_cnt[d]);
      @(posedge clk);
    end
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    int f;
    int s;
    int r;
    rst    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    frames = '0;
`ifdef PATGEN_RUNTIME_PAT_EN
    set_pattern(PATTERN, 5'd5);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check_outputs(d, "reset", 0, 0, 0, 0, 0);
      last_cnt[d] = 0;
    end

    run_case(1, 0, 0);
    idle_cycles(2);
    run_case(3, 0, 0);
    idle_cycles(2);
    run_case(2, 0, 0);
    idle_cycles(2);
    run_case(0, 23, 0);
    idle_cycles(2);
    run_case(1, 0, 3);
    idle_cycles(2);
    run_case(0, 1800, 0);
    idle_cycles(2);
`ifdef PATGEN_RUNTIME_PAT_EN
    set_pattern(5'b10110, 5'd4);
    run_case(1, 0, 0);
    idle_cycles(2);
`endif

    for (int n = 0; n < 30; n++) begin
`ifdef PATGEN_RUNTIME_PAT_EN
      set_pattern(PAT_W'($urandom), 5'($urandom_range(0, 8)));
`endif
      f = $urandom_range(0, 4);
      if (f == 0) s = $urandom_range(1, 40);
      else s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0;
      r = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0;
      run_case(f, s, r);
      idle_cycles($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
